// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command front-end for the combinational ALU: collects opcode/A/B,
// presents them to the ALU for one cycle, captures the result and hands it out.
module alu_cmd_sequencer #(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [WIDTH-1:0]          cmd_data,
    output logic signed [WIDTH-1:0]   alu_in1,
    output logic signed [WIDTH-1:0]   alu_in2,
    output logic [OP_WIDTH-1:0]       alu_op,
    output logic                      alu_nvalid_data,
    input  logic signed [2*WIDTH-1:0] alu_out,
    input  logic                      alu_zero,
    input  logic                      alu_error,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*WIDTH-1:0]        res_data,
    output logic                      res_zero,
    output logic                      res_error
);

    typedef enum logic [2:0] {
        S_OP,
        S_A,
        S_B,
        S_EXEC,
        S_RES
    } state_t;

    state_t                    state_q, state_d;
    logic [OP_WIDTH-1:0]       op_q, op_d;
    logic signed [WIDTH-1:0]   in1_q, in1_d;
    logic signed [WIDTH-1:0]   in2_q, in2_d;
    logic                      nvalid_q, nvalid_d;
    logic [2*WIDTH-1:0]        resData_q, resData_d;
    logic                      resZero_q, resZero_d;
    logic                      resError_q, resError_d;
    logic                      cmdAccept;
    logic                      cmdReadyState;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_OP;
            op_q       <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            nvalid_q   <= 1'b1;
            resData_q  <= '0;
            resZero_q  <= 1'b0;
            resError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            nvalid_q   <= nvalid_d;
            resData_q  <= resData_d;
            resZero_q  <= resZero_d;
            resError_q <= resError_d;
        end
    end

    assign cmdReadyState = (state_q == S_OP) || (state_q == S_A) || (state_q == S_B);
    assign cmdAccept     = cmd_valid && cmdReadyState;

    // nvalid_d is cleared on the B transfer so the registered flag is low exactly in S_EXEC
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        nvalid_d   = 1'b1;
        resData_d  = resData_q;
        resZero_d  = resZero_q;
        resError_d = resError_q;
        unique case (state_q)
            S_OP: begin
                if (cmdAccept) begin
                    op_d    = cmd_data[OP_WIDTH-1:0];
                    state_d = S_A;
                end
            end
            S_A: begin
                if (cmdAccept) begin
                    in1_d   = cmd_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (cmdAccept) begin
                    in2_d    = cmd_data;
                    nvalid_d = 1'b0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                resData_d  = alu_out;
                resZero_d  = alu_zero;
                resError_d = alu_error;
                state_d    = S_RES;
            end
            S_RES: begin
                if (res_ready) begin
                    state_d = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase
    end

    // Gate with reset so no byte can be taken while the block is held in reset
    assign cmd_ready       = cmdReadyState && !reset;
    assign res_valid       = (state_q == S_RES);
    assign alu_in1         = in1_q;
    assign alu_in2         = in2_q;
    assign alu_op          = op_q;
    assign alu_nvalid_data = nvalid_q;
    assign res_data        = resData_q;
    assign res_zero        = resZero_q;
    assign res_error       = resError_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU model, a table of
// directed commands, and hand-written reset / back-pressure / gap sequences.
module tb_alu_cmd_sequencer;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    logic               clk;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_data;
    logic signed [7:0]  alu_in1;
    logic signed [7:0]  alu_in2;
    logic [2:0]         alu_op;
    logic               alu_nvalid_data;
    logic signed [15:0] alu_out;
    logic               alu_zero;
    logic               alu_error;
    logic               res_valid;
    logic               res_ready;
    logic [15:0]        res_data;
    logic               res_zero;
    logic               res_error;

    int testsRun;
    int testsFailed;
    int nvalidLowCount;
    bit monitorOn;

    alu_cmd_sequencer #(.WIDTH(8), .OP_WIDTH(3)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data(cmd_data),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_op(alu_op),
        .alu_nvalid_data(alu_nvalid_data),
        .alu_out(alu_out),
        .alu_zero(alu_zero),
        .alu_error(alu_error),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_zero(res_zero),
        .res_error(res_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational ALU
    always_comb begin
        logic signed [15:0] a16;
        logic signed [15:0] b16;
        a16       = alu_in1;
        b16       = alu_in2;
        alu_out   = 16'sd0;
        alu_error = 1'b0;
        case (alu_op)
            OP_ADD: alu_out = a16 + b16;
            OP_SUB: alu_out = a16 - b16;
            OP_MUL: alu_out = a16 * b16;
            OP_DIV: begin
                if (b16 == 16'sd0) begin
                    alu_out   = -16'sd1;
                    alu_error = 1'b1;
                end else begin
                    alu_out = a16 / b16;
                end
            end
            default: begin
                alu_out   = -16'sd1;
                alu_error = 1'b1;
            end
        endcase
        alu_zero = (alu_out == 16'sd0);
    end

    always @(negedge clk) begin
        if (monitorOn && !alu_nvalid_data) nvalidLowCount++;
    end

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expData;
        logic        expZero;
        logic        expError;
    } vector_t;

    vector_t vectors[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one byte and hold it until the sequencer takes it (bounded)
    task automatic applyStimulus(input logic [7:0] value);
        bit accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = value;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (cmd_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!accepted) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycle();
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Stream a full command and check the EXEC cycle, result cycle and return to idle
    task automatic runCommand(input string name, input vector_t v, input bit gaps);
        res_ready = 1'b1;
        applyStimulus(v.op);
        if (gaps) idleCycle();
        applyStimulus(v.a);
        if (gaps) idleCycle();
        applyStimulus(v.b);
        checkOutput({name, "_exec_res_valid"}, {31'd0, res_valid}, 32'd0);
        checkOutput({name, "_exec_nvalid"}, {31'd0, alu_nvalid_data}, 32'd0);
        checkOutput({name, "_alu_op"}, {29'd0, alu_op}, {29'd0, v.op[2:0]});
        checkOutput({name, "_alu_in1"}, {24'd0, alu_in1}, {24'd0, v.a});
        checkOutput({name, "_alu_in2"}, {24'd0, alu_in2}, {24'd0, v.b});
        @(posedge clk);
        #1;
        checkOutput({name, "_res_valid"}, {31'd0, res_valid}, 32'd1);
        checkOutput({name, "_res_data"}, {16'd0, res_data}, {16'd0, v.expData});
        checkOutput({name, "_res_zero"}, {31'd0, res_zero}, {31'd0, v.expZero});
        checkOutput({name, "_res_error"}, {31'd0, res_error}, {31'd0, v.expError});
        checkOutput({name, "_res_nvalid"}, {31'd0, alu_nvalid_data}, 32'd1);
        checkOutput({name, "_res_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({name, "_done_res_valid"}, {31'd0, res_valid}, 32'd0);
        checkOutput({name, "_done_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        checkOutput({name, "_nvalid"}, {31'd0, alu_nvalid_data}, 32'd1);
        checkOutput({name, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        checkOutput({name, "_alu_in1"}, {24'd0, alu_in1}, 32'd0);
        checkOutput({name, "_alu_in2"}, {24'd0, alu_in2}, 32'd0);
        checkOutput({name, "_alu_op"}, {29'd0, alu_op}, 32'd0);
        checkOutput({name, "_res_data"}, {16'd0, res_data}, 32'd0);
        checkOutput({name, "_res_zero"}, {31'd0, res_zero}, 32'd0);
        checkOutput({name, "_res_error"}, {31'd0, res_error}, 32'd0);
    endtask

    task automatic pulseResetMidCycle(input string name);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkResetValues(name);
        @(posedge clk);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vector_t v;
        testsRun       = 0;
        testsFailed    = 0;
        nvalidLowCount = 0;
        monitorOn      = 1'b0;
        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_data       = 8'h00;
        res_ready      = 1'b1;

        vectors[0] = '{{5'd0, OP_ADD}, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0};
        vectors[1] = '{{5'd0, OP_DIV}, 8'h05, 8'h00, 16'hFFFF, 1'b0, 1'b1};
        vectors[2] = '{{5'd0, OP_ADD}, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0};
        vectors[3] = '{{5'd0, OP_SUB}, 8'h02, 8'h05, 16'hFFFD, 1'b0, 1'b0};
        vectors[4] = '{{5'd0, OP_MUL}, 8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0};
        vectors[5] = '{8'h07, 8'h11, 8'h22, 16'hFFFF, 1'b0, 1'b1};
        vectors[6] = '{8'hF8, 8'h10, 8'h20, 16'h0030, 1'b0, 1'b0};
        vectors[7] = '{{5'd0, OP_DIV}, 8'h9C, 8'h07, 16'hFFF2, 1'b0, 1'b0};

        // Power-on reset held across edges
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("por");
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("por_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            runCommand($sformatf("vec%0d", i), vectors[i], 1'b0);
        end

        // Async reset while a result is pending: everything clears immediately
        res_ready = 1'b0;
        applyStimulus({5'd0, OP_ADD});
        applyStimulus(8'h7F);
        applyStimulus(8'h01);
        @(posedge clk);
        #1;
        checkOutput("pend_res_valid", {31'd0, res_valid}, 32'd1);
        checkOutput("pend_res_data", {16'd0, res_data}, 32'h0080);
        pulseResetMidCycle("rst_pend");
        checkOutput("rst_pend_after_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Back-pressure: result held 10 cycles, bytes offered meanwhile are ignored
        res_ready = 1'b0;
        applyStimulus({5'd0, OP_SUB});
        applyStimulus(8'h03);
        applyStimulus(8'h03);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data  = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bp%0d_res_valid", i), {31'd0, res_valid}, 32'd1);
            checkOutput($sformatf("bp%0d_res_data", i), {16'd0, res_data}, 32'd0);
            checkOutput($sformatf("bp%0d_res_zero", i), {31'd0, res_zero}, 32'd1);
            checkOutput($sformatf("bp%0d_cmd_ready", i), {31'd0, cmd_ready}, 32'd0);
            checkOutput($sformatf("bp%0d_alu_in1", i), {24'd0, alu_in1}, 32'd3);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("bp_release_alu_op", {29'd0, alu_op}, {29'd0, OP_SUB});

        // Gapped byte stream; ALU inputs may be flagged valid for one cycle only
        nvalidLowCount = 0;
        monitorOn      = 1'b1;
        v = '{{5'd0, OP_MUL}, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0};
        runCommand("gap_mul", v, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        monitorOn = 1'b0;
        checkOutput("gap_nvalid_low_cycles", nvalidLowCount, 32'd1);

        // Reset after A accepted: partial command is dropped, next one is clean
        applyStimulus({5'd0, OP_ADD});
        applyStimulus(8'h55);
        checkOutput("partial_alu_in1", {24'd0, alu_in1}, 32'h55);
        pulseResetMidCycle("rst_partial");
        checkOutput("rst_partial_res_valid", {31'd0, res_valid}, 32'd0);
        v = '{{5'd0, OP_MUL}, 8'h02, 8'h03, 16'h0006, 1'b0, 1'b0};
        runCommand("post_rst_mul", v, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
